// File: rtl/bin8_to_bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bin8_to_bcd_pkg
//  Description : Shared widths and FSM state encoding for the sequential
//                8-bit binary to 3-digit BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bin8_to_bcd_pkg;

  localparam int BIN_W    = 8;                 // binary input width
  localparam int NDIG     = 3;                 // hundreds, tens, ones
  localparam int DIG_W    = 4;                 // one BCD digit
  localparam int ACC_W    = NDIG * DIG_W;      // packed BCD accumulator
  localparam int CNT_W    = 3;                 // bit counter, 0..7
  localparam logic [CNT_W-1:0] CNT_LAST = 3'd7; // index of the final shift

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : bin8_to_bcd_pkg
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3
//  Description : Double-dabble digit correction. A digit of 5..9 gets +3 so
//                that the following left shift carries into the next digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3
  import bin8_to_bcd_pkg::*;
(
  input  logic [DIG_W-1:0] din_i,
  output logic [DIG_W-1:0] dout_o
);

  // Inputs above 9 never occur inside a valid accumulator; they wrap harmlessly.
  assign dout_o = (din_i >= 4'd5) ? (din_i + 4'd3) : din_i;

endmodule : bcd_add3
`default_nettype wire

// File: rtl/bin8_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin8_to_bcd_seq
//  Description : Sequential shift-add-3 (double dabble) converter, one input
//                bit per clock, MSB first. IDLE -> SHIFT (8 cycles) -> DONE.
//                busy/done are registered Moore outputs; bcd holds the last
//                result and changes only on the SHIFT->DONE edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin8_to_bcd_seq
  import bin8_to_bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] bcd
);

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [ACC_W-1:0]   bcd_q,   bcd_d;
  logic               busy_q,  done_q;

  logic [ACC_W-1:0]        acc_corr;
  logic [ACC_W+BIN_W-1:0]  shift_nxt;

  // Per-digit +3 correction applied to the current accumulator.
  genvar g;
  generate
    for (g = 0; g < NDIG; g++) begin : g_digit
      bcd_add3 u_add3 (
        .din_i  (acc_q[g*DIG_W +: DIG_W]),
        .dout_o (acc_corr[g*DIG_W +: DIG_W])
      );
    end
  endgenerate

  // Corrected accumulator and shift register move left together by one bit.
  assign shift_nxt = {acc_corr, shreg_q} << 1;

  // Next-state, datapath and result-capture logic.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          shreg_d = bin;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        acc_d   = shift_nxt[ACC_W+BIN_W-1:BIN_W];
        shreg_d = shift_nxt[BIN_W-1:0];
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == CNT_LAST) begin
          // Last bit shifted in: the accumulator now holds the final digits.
          state_d = DONE;
          bcd_d   = shift_nxt[ACC_W+BIN_W-1:BIN_W];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All converter state; busy/done are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule : bin8_to_bcd_seq
`default_nettype wire

// File: tb/tb_bin8_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin8_to_bcd_seq
//  Description : Self-checking bench for bin8_to_bcd_seq. A cycle-level
//                behavioural model predicts busy/done/bcd every cycle; directed
//                conversions pin known results with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin8_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int n_tests = 0;
  int n_fail  = 0;

  bin8_to_bcd_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  // Decimal digits by plain arithmetic.
  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_phase 0 = idle, 1..8 = converting cycles, 9 = done cycle.
  int          m_phase = 0;
  int          m_val   = 0;
  logic [11:0] m_bcd   = '0;
  bit          m_valid = 1'b0;
  int          n_acc   = 0;
  int          n_done  = 0;

  // Behavioural model advanced on every rising edge from the driven inputs.
  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (rst) begin
      m_phase <= 0;
      m_bcd   <= '0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase <= 1;
        m_val   <= int'(bin);
        n_acc   <= n_acc + 1;
      end
    end else if (m_phase == 8) begin
      m_phase <= 9;
      m_bcd   <= to_bcd(m_val);
    end else if (m_phase == 9) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  // Compare DUT outputs against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 8));
      chk("done", 32'(done), 32'(m_phase == 9));
      chk("bcd",  32'(bcd),  32'(m_bcd));
      if (done) begin
        n_done <= n_done + 1;
        if (bcd[11:8] > 4'd2 || bcd[7:4] > 4'd9 || bcd[3:0] > 4'd9)
          chk("digit_range", 32'(bcd), 32'(m_bcd) | 32'h1000);
      end
    end
  end

  // One conversion from IDLE with literal expectation, latency and busy width.
  task automatic conv(input logic [7:0] b, input logic [11:0] exp, input string nm);
    int cyc;
    int nbusy;
    cyc = 0;
    nbusy = 0;
    bin = b;
    start = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) nbusy++;
      if (cyc == 1) begin
        start = 1'b0;
        bin = 8'($urandom);
      end
    end while (!done && cyc < 30);
    chk({nm, "_bcd"}, 32'(bcd), 32'(exp));
    chk({nm, "_latency"}, 32'(cyc), 32'd9);
    chk({nm, "_busy_cycles"}, 32'(nbusy), 32'd8);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int acc0;
    int done0;
    rst = 1'b1;
    start = 1'b0;
    bin = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_bcd",  32'(bcd),  32'd0);
    // Idle with start low stays quiet.
    bin = 8'd77;
    repeat (3) @(negedge clk);
    chk("idle_hold_bcd", 32'(bcd), 32'd0);

    conv(8'd6,   12'h006, "p3x2");
    conv(8'd27,  12'h027, "p9x3");
    conv(8'd33,  12'h033, "p11x3");
    conv(8'd14,  12'h014, "p2x7");
    conv(8'd100, 12'h100, "p10x10");
    conv(8'd48,  12'h048, "p8x6");
    conv(8'd0,   12'h000, "zero");
    conv(8'd225, 12'h225, "p15x15");
    conv(8'd255, 12'h255, "max");
    conv(8'd99,  12'h099, "n99");

    // Start held high: only one conversion in flight, bin change ignored.
    bin = 8'd27;
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) bin = 8'd200;
    end while (!done && cyc < 30);
    chk("held_bcd", 32'(bcd), 32'h027);
    chk("held_latency", 32'(cyc), 32'd9);
    @(negedge clk);
    chk("held_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    chk("held_restart", 32'(busy), 32'd1);
    start = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done && cyc < 30);
    chk("held_second_bcd", 32'(bcd), 32'h200);
    @(negedge clk);

    // Reset four cycles into a conversion aborts it.
    bin = 8'd225;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) cyc++;
    end
    chk("abort_no_done", 32'(cyc), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'h000);
    conv(8'd48, 12'h048, "after_rst");

    // Exhaustive sweep with random gaps and spurious starts while busy.
    acc0 = n_acc;
    done0 = n_done;
    for (int v = 0; v < 256; v++) begin
      bin = 8'(v);
      start = 1'b1;
      @(negedge clk);
      cyc = 0;
      do begin
        start = ($urandom_range(0, 1) == 1);
        bin = 8'($urandom);
        @(negedge clk);
        cyc++;
      end while (!done && cyc < 30);
      start = 1'b0;
      chk("sweep_bcd", 32'(bcd), 32'(to_bcd(v)));
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("sweep_done_count", 32'(n_done - done0), 32'(n_acc - acc0));

    // Fully random traffic including occasional reset.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 3) == 0);
      bin = 8'($urandom);
      rst = ($urandom_range(0, 60) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bin8_to_bcd_seq
`default_nettype wire

// File: doc/bin8_to_bcd_seq.md
BIN8_TO_BCD_SEQ -- requirements
Module: bin8_to_bcd_seq

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request a conversion of bin; sampled only in IDLE.
REQ-005 bin  input  8  unsigned binary value, e.g. the product P of the 4-bit multiplier.
REQ-006 busy  output  1  high while converting (SHIFT state).
REQ-007 done  output  1  one-cycle pulse; bcd holds the new result when done is high.
REQ-008 bcd  output  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] ones.

Function
REQ-009 The block SHALL convert using a shift-add-3 (double-dabble) algorithm, one bit per clock, MSB of bin first.
REQ-010 FSM states SHALL be IDLE, SHIFT and DONE; reset state is IDLE.
REQ-011 IDLE->SHIFT on the edge where start=1:
- bin is captured into the 8-bit shift register.
- the 12-bit digit accumulator is cleared.
- the bit counter is set to 0.
REQ-012 IDLE with start=0 SHALL hold state, with all outputs stable.
REQ-013 Each edge in SHIFT SHALL do the following, in order:
- add 3 to each digit of the accumulator whose value is >=5.
- shift {accumulator, shift register} left by 1.
- increment the counter.
REQ-014 SHIFT->DONE on the 8th shift edge; on that same edge the corrected accumulator is loaded into the bcd output register.
REQ-015 DONE->IDLE unconditionally on the next edge; done = (state==DONE), a Moore output with no combinational path from inputs.
REQ-016 Latency: start sampled at edge k -> done high in the cycle after edge k+8, and the same for every input value.
REQ-017 busy = (state==SHIFT); busy and done are never high together.
REQ-018 start while in SHIFT or DONE SHALL be ignored; the in-flight conversion and bin capture are unaffected.
REQ-019 Changes on bin after capture SHALL NOT affect the result.
REQ-020 bcd SHALL hold the last result until the next conversion completes; it changes only on the SHIFT->DONE edge.
REQ-021 The full input range 0..255 SHALL convert correctly; every output digit is <=9, and the hundreds digit is <=2.
REQ-022 Counter width is 3 bits, with a terminal count of 7; the counter does not wrap back into SHIFT.

Reset
REQ-023 On rst=1 at an edge:
- state goes to IDLE.
- busy, done and bcd become 0.
- the shift register, accumulator and counter are cleared.
REQ-024 Reset mid-conversion (SHIFT or DONE) SHALL abort without a done pulse; the next start after reset behaves as from power-up.
REQ-025 rst SHALL take priority over start on the same edge.

Structure
REQ-026 Shared package bin8_to_bcd_pkg SHALL hold:
- BIN_W=8, NDIG=3, DIG_W=4.
- the state encoding (IDLE, SHIFT, DONE).
REQ-027 Sub-module bcd_add3 (4-bit in, 4-bit out; adds 3 if >=5, else passes through) SHALL be instantiated NDIG times.
REQ-028 All state SHALL reside in one clocked process; next-state and correction logic are combinational.

Verification
REQ-029 bin=8'd6 (3x2), start pulse -> done exactly 9 cycles later, bcd=12'h006; busy high for 8 cycles.
REQ-030 Sequence 27, 33, 14, 100, 48 (products 9x3, 11x3, 2x7, 10x10, 8x6) -> bcd 12'h027, 12'h033, 12'h014, 12'h100, 12'h048.
REQ-031 Boundary values:
- bin=0 -> 12'h000.
- bin=225 (15x15) -> 12'h225.
- bin=255 -> 12'h255.
- bin=99 -> 12'h099.
REQ-032 Start held high continuously with bin=27 for 3 cycles, then bin=200 -> only one conversion is in flight; result is 12'h027; the next accepted start occurs in IDLE after DONE.
REQ-033 rst asserted 4 cycles into a conversion of bin=225 -> no done; bcd=12'h000; a subsequent start with bin=48 gives 12'h048 after 9 cycles.
REQ-034 Exhaustive sweep of 0..255 against a reference model (hundreds=bin/100, tens=(bin/10)%10, ones=bin%10) -> zero mismatches; done count equals start count.
